serial_minority_tally: RTL and testbench

- Sequential counterpart to the parallel five-input Minority gate.
- Accepts one ballot bit per valid/ready handshake from a serial voter link and assembles the ballot vector.
- After exactly N accepted ballots it presents the full vector, the ones count, and the minority/majority verdicts, then holds them until acknowledged.
- Sits between a serial ballot source and any consumer that would otherwise need all N votes in parallel.

---
 rtl/tally_pkg.sv | 14 +
 rtl/ballot_shift_counter.sv | 55 +++++
 rtl/serial_minority_tally.sv | 83 ++++++++
 tb/tb_serial_minority_tally.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tally_pkg.sv
// Shared types and helpers for the serial minority tally.
package tally_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } tally_state_t;

    // Minority verdict: strictly fewer than half of n voted yes.
    function automatic logic minority_of(input int unsigned count, input int unsigned n);
        return ((2 * count) < n);
    endfunction

endpackage

// File: rtl/ballot_shift_counter.sv
// Ballot index counter, ballot vector and ones accumulator for one round.
// The first accepted ballot lands in bit N-1, the last one in bit 0.
module ballot_shift_counter
    import tally_pkg::*;
#(
    parameter int N  = 5,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic          bit_i,
    output logic [N-1:0]  votes_o,
    output logic [CW-1:0] ones_o,
    output logic [CW-1:0] idx_o,
    output logic          last_o
);

    logic [N-1:0]  votes_q, votes_d;
    logic [CW-1:0] ones_q,  ones_d;
    logic [CW-1:0] idx_q,   idx_d;

    // Next-state: clear wins over a ballot write; the slot is picked by idx.
    always_comb begin
        votes_d = votes_q;
        ones_d  = ones_q;
        idx_d   = idx_q;
        if (clear_i) begin
            votes_d = '0;
            ones_d  = '0;
            idx_d   = '0;
        end else if (enable_i) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(N - 1 - i) == idx_q) begin
                    votes_d[i] = bit_i;
                end
            end
            ones_d = ones_q + CW'(bit_i);
            idx_d  = idx_q + CW'(1);
        end
    end

    // Round registers.
    always_ff @(posedge clock) begin
        votes_q <= votes_d;
        ones_q  <= ones_d;
        idx_q   <= idx_d;
    end

    assign votes_o = votes_q;
    assign ones_o  = ones_q;
    assign idx_o   = idx_q;
    assign last_o  = (idx_q == CW'(N - 1));

endmodule

// File: rtl/serial_minority_tally.sv
// Serial ballot collector: gathers N ballots over a valid/ready link, then
// presents the vector, the ones count and the minority/majority verdicts
// until the consumer acknowledges or the round is aborted.
module serial_minority_tally
    import tally_pkg::*;
#(
    parameter  int N  = 5,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vote_valid,
    input  logic          vote_bit,
    output logic          vote_ready,
    input  logic          abort,
    output logic          result_valid,
    input  logic          result_ack,
    output logic [N-1:0]  votes,
    output logic [CW-1:0] ones_count,
    output logic          y,
    output logic          majority
);

    tally_state_t state_q, state_d;

    logic          accept;
    logic          clear;
    logic          last;
    logic [CW-1:0] idx;

    // Abort beats a ballot offered in the same cycle.
    assign accept = vote_valid && vote_ready && !abort;
    assign clear  = reset || abort || ((state_q == DONE) && result_ack);

    ballot_shift_counter #(
        .N  (N),
        .CW (CW)
    ) u_counter (
        .clock    (clock),
        .clear_i  (clear),
        .enable_i (accept),
        .bit_i    (vote_bit),
        .votes_o  (votes),
        .ones_o   (ones_count),
        .idx_o    (idx),
        .last_o   (last)
    );

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: last accepted ballot closes the round; ack or abort reopens it.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (accept && last) state_d = DONE;
                DONE:    if (result_ack)     state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    // Outputs depend only on registered state, so no input-to-handshake paths.
    always_comb begin
        vote_ready   = (state_q == COLLECT);
        result_valid = (state_q == DONE);
        y            = minority_of(int'(ones_count), N);
        majority     = ((2 * int'(ones_count)) > N);
    end

    logic unused_idx;
    assign unused_idx = ^idx;

endmodule

// File: tb/tb_serial_minority_tally.sv
// Bench for serial_minority_tally (N=5): a queue-based round model checked
// every cycle, plus literal expectations from hand-worked rounds.
module tb_serial_minority_tally;
    localparam int N  = 5;
    localparam int CW = $clog2(N + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vote_valid = 1'b0;
    logic          vote_bit = 1'b0;
    logic          vote_ready;
    logic          abort = 1'b0;
    logic          result_valid;
    logic          result_ack = 1'b0;
    logic [N-1:0]  votes;
    logic [CW-1:0] ones_count;
    logic          y;
    logic          majority;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    int ballots[$];

    serial_minority_tally #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .vote_valid   (vote_valid),
        .vote_bit     (vote_bit),
        .vote_ready   (vote_ready),
        .abort        (abort),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .votes        (votes),
        .ones_count   (ones_count),
        .y            (y),
        .majority     (majority)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Round model: the list of ballots accepted so far.
    always @(posedge clock) begin
        if (reset || abort || (ballots.size() == N && result_ack))
            ballots.delete();
        else if (ballots.size() < N && vote_valid)
            ballots.push_back(int'(vote_bit));
        started <= 1'b1;
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (started) begin
            int ones;
            int v;
            bit done;
            ones = 0;
            v    = 0;
            done = (ballots.size() == N);
            foreach (ballots[k]) begin
                ones += ballots[k];
                v    += ballots[k] << (N - 1 - k);
            end
            chk("m_ready",    int'(vote_ready),   int'(!done));
            chk("m_rvalid",   int'(result_valid), int'(done));
            chk("m_votes",    int'(votes),        v);
            chk("m_ones",     int'(ones_count),   ones);
            chk("m_y",        int'(y),            int'(2 * ones < N));
            chk("m_majority", int'(majority),     int'(2 * ones > N));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic b);
        vote_valid = 1'b1;
        vote_bit   = b;
        tick();
    endtask

    task automatic idle(input int n);
        vote_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic ack_once();
        vote_valid = 1'b0;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    initial begin
        logic [N-1:0] held_votes;
        logic [N-1:0] vec;

        tick();
        tick();
        chk("rst_rvalid", int'(result_valid), 0);
        chk("rst_votes",  int'(votes), 0);
        chk("rst_y",      int'(y), 1);
        chk("rst_maj",    int'(majority), 0);
        chk("rst_ready",  int'(vote_ready), 1);
        reset = 1'b0;

        // All zeros, valid held high.
        send(0); send(0); send(0); send(0);
        chk("z_not_yet", int'(result_valid), 0);
        send(0);
        vote_valid = 1'b0;
        chk("z_rvalid", int'(result_valid), 1);
        chk("z_votes",  int'(votes), 0);
        chk("z_ones",   int'(ones_count), 0);
        chk("z_y",      int'(y), 1);
        chk("z_maj",    int'(majority), 0);
        ack_once();

        // 1,1,0,0,0 then hold with source still offering.
        send(1); send(1); send(0); send(0); send(0);
        chk("h_votes", int'(votes), 5'b11000);
        chk("h_ones",  int'(ones_count), 2);
        chk("h_y",     int'(y), 1);
        held_votes = votes;
        vote_valid = 1'b1;
        vote_bit   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("h_hold_votes", int'(votes), int'(held_votes));
            chk("h_hold_ready", int'(vote_ready), 0);
            chk("h_hold_rv",    int'(result_valid), 1);
        end
        ack_once();

        // 1,0,1,1,0 with gaps.
        send(1); idle(2); send(0); idle(1); send(1); idle(3); send(1); idle(1); send(0);
        vote_valid = 1'b0;
        chk("g_votes", int'(votes), 5'b10110);
        chk("g_ones",  int'(ones_count), 3);
        chk("g_y",     int'(y), 0);
        chk("g_maj",   int'(majority), 1);
        ack_once();
        chk("g_ack_rv",    int'(result_valid), 0);
        chk("g_ack_votes", int'(votes), 0);
        chk("g_ack_ready", int'(vote_ready), 1);

        // Abort mid-round with a ballot offered.
        send(1); send(1); send(1);
        abort = 1'b1; vote_valid = 1'b1; vote_bit = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_ones",  int'(ones_count), 0);
        chk("a_votes", int'(votes), 0);
        send(0); send(0); send(0); send(0); send(1);
        vote_valid = 1'b0;
        chk("a_votes2", int'(votes), 5'b00001);
        chk("a_y",      int'(y), 1);
        chk("a_rv",     int'(result_valid), 1);

        // Abort while DONE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ad_rv", int'(result_valid), 0);

        // Reset in DONE with ack also high.
        send(1); send(1); send(1); send(1); send(1);
        vote_valid = 1'b0;
        chk("r_maj", int'(majority), 1);
        reset = 1'b1; result_ack = 1'b1;
        tick();
        reset = 1'b0; result_ack = 1'b0;
        chk("r_rv",    int'(result_valid), 0);
        chk("r_votes", int'(votes), 0);
        chk("r_y",     int'(y), 1);
        chk("r_ready", int'(vote_ready), 1);

        // Reset during COLLECT with a ballot offered.
        send(1); send(1);
        reset = 1'b1; vote_valid = 1'b1; vote_bit = 1'b1;
        tick();
        reset = 1'b0; vote_valid = 1'b0;
        chk("rc_ones", int'(ones_count), 0);

        // All 32 rounds back-to-back, 6 cycles each.
        for (int r = 0; r < 32; r++) begin
            vec = N'(r);
            for (int k = 0; k < N; k++) begin
                chk("sw_ready", int'(vote_ready), 1);
                send(vec[N-1-k]);
            end
            chk("sw_rv",    int'(result_valid), 1);
            chk("sw_votes", int'(votes), r);
            chk("sw_y",     int'(y), int'($countones(vec) < 3));
            ack_once();
            chk("sw_rv0",   int'(result_valid), 0);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
